// File: rtl/alu_exec_stage.sv
// alu_exec_stage: execute-stage ALU with a registered EX/MEM output, valid/ready
// handshakes on both sides, and an iterative signed multiply-accumulate (MULA)
// into HI/LO.
// Optional build macro: ALU_EXEC_OVERFLOW_EN enables signed-overflow detection
// for ADD/SUB. Without it the Overflow port is tied to 0.
module alu_exec_stage #(
   parameter int unsigned MUL_BITS_PER_CYCLE = 2
) (
   input  logic        CLK,
   input  logic        Reset_L,
   input  logic        Flush,
   input  logic        InValid,
   output logic        InReady,
   input  logic [3:0]  ALUCtrl,
   input  logic [31:0] BusA,
   input  logic [31:0] BusB,
   input  logic [4:0]  Shamt,
   output logic        OutValid,
   input  logic        OutReady,
   output logic [31:0] ALUResult,
   output logic        Zero,
   output logic        Overflow,
   output logic        BadOp,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   localparam int unsigned K  = MUL_BITS_PER_CYCLE;
   localparam int unsigned N  = 32 / MUL_BITS_PER_CYCLE;
   localparam int unsigned CW = 6;

   typedef enum logic [1:0] {
      st_idle,
      st_mul,
      st_wb
   } state_t;

   typedef enum logic [3:0] {
      op_and  = 4'h0,
      op_or   = 4'h1,
      op_add  = 4'h2,
      op_sll  = 4'h3,
      op_srl  = 4'h4,
      op_mula = 4'h5,
      op_sub  = 4'h6,
      op_slt  = 4'h7,
      op_addu = 4'h8,
      op_subu = 4'h9,
      op_xor  = 4'hA,
      op_sltu = 4'hB,
      op_nor  = 4'hC,
      op_sra  = 4'hD,
      op_lui  = 4'hE,
      op_bad  = 4'hF
   } op_t;

   state_t        state, state_nxt;
   op_t           op;
   logic          out_free;
   logic          accept;
   logic          accept_alu;
   logic          accept_mula;
   logic          wb_commit;

   logic [31:0]   sum, diff;
   logic [31:0]   alu_res;
   logic          alu_bad;

   logic [63:0]   mcand;
   logic [31:0]   mplier;
   logic [63:0]   prod;
   logic [63:0]   step_sum;
   logic          mul_neg;
   logic [CW-1:0] count;
   logic [31:0]   abs_a, abs_b;
   logic [63:0]   prod_signed;
   logic [63:0]   acc_nxt;

   assign op          = op_t'(ALUCtrl);
   assign sum         = BusA + BusB;
   assign diff        = BusA - BusB;
   assign abs_a       = BusA[31] ? (~BusA + 32'd1) : BusA;
   assign abs_b       = BusB[31] ? (~BusB + 32'd1) : BusB;
   assign prod_signed = mul_neg ? (~prod + 64'd1) : prod;
   assign acc_nxt     = {HI, LO} + prod_signed;
   assign accept_alu  = accept && (op != op_mula);
   assign accept_mula = accept && (op == op_mula);

   // Single-cycle ALU result and bad-opcode decode
   always_comb begin
      alu_res = '0;
      alu_bad = 1'b0;
      case (op)
         op_and:  alu_res = BusA & BusB;
         op_or:   alu_res = BusA | BusB;
         op_xor:  alu_res = BusA ^ BusB;
         op_nor:  alu_res = ~(BusA | BusB);
         op_add:  alu_res = sum;
         op_addu: alu_res = sum;
         op_sub:  alu_res = diff;
         op_subu: alu_res = diff;
         op_slt:  alu_res = {31'b0, $signed(BusA) < $signed(BusB)};
         op_sltu: alu_res = {31'b0, BusA < BusB};
         op_sll:  alu_res = BusB << Shamt;
         op_srl:  alu_res = BusB >> Shamt;
         op_sra:  alu_res = $signed(BusB) >>> Shamt;
         op_lui:  alu_res = {BusB[15:0], 16'h0000};
         op_mula: alu_res = '0;
         default: alu_bad = 1'b1;
      endcase
   end

   // One multiplier iteration: add K shifted partial products of |A|
   always_comb begin
      step_sum = prod;
      for (int unsigned j = 0; j < K; j++) begin
         if (mplier[j]) begin
            step_sum = step_sum + (mcand << j);
         end
      end
   end

   // FSM state register
   always_ff @(posedge CLK) begin
      if (!Reset_L) begin
         state <= st_idle;
      end else begin
         state <= state_nxt;
      end
   end

   // FSM next state, handshake and commit strobes
   always_comb begin
      state_nxt = state;
      InReady   = 1'b0;
      accept    = 1'b0;
      wb_commit = 1'b0;
      out_free  = !OutValid || OutReady;
      case (state)
         st_idle: begin
            InReady = out_free && !Flush;
            accept  = InValid && InReady;
            if (accept && (op == op_mula)) begin
               state_nxt = st_mul;
            end
         end
         st_mul: begin
            if (count == CW'(N - 1)) begin
               state_nxt = st_wb;
            end
         end
         st_wb: begin
            if (out_free && !Flush) begin
               wb_commit = 1'b1;
               state_nxt = st_idle;
            end
         end
         default: state_nxt = st_idle;
      endcase
      if (Flush) begin
         state_nxt = st_idle;
      end
   end

   // Multiplier operand/partial-product registers
   always_ff @(posedge CLK) begin
      if (!Reset_L) begin
         mcand   <= '0;
         mplier  <= '0;
         prod    <= '0;
         mul_neg <= 1'b0;
         count   <= '0;
      end else if (accept_mula) begin
         mcand   <= {32'b0, abs_a};
         mplier  <= abs_b;
         prod    <= '0;
         mul_neg <= BusA[31] ^ BusB[31];
         count   <= '0;
      end else if (state == st_mul && !Flush) begin
         prod    <= step_sum;
         mcand   <= mcand << K;
         mplier  <= mplier >> K;
         count   <= count + 1'b1;
      end
   end

   // HI/LO accumulator and EX/MEM output register
   always_ff @(posedge CLK) begin
      if (!Reset_L) begin
         HI        <= '0;
         LO        <= '0;
         OutValid  <= 1'b0;
         ALUResult <= '0;
         Zero      <= 1'b0;
         BadOp     <= 1'b0;
      end else begin
         if (wb_commit) begin
            {HI, LO} <= acc_nxt;
         end
         if (Flush) begin
            OutValid <= 1'b0;
         end else if (accept_alu) begin
            OutValid  <= 1'b1;
            ALUResult <= alu_res;
            Zero      <= (alu_res == '0);
            BadOp     <= alu_bad;
         end else if (wb_commit) begin
            OutValid  <= 1'b1;
            ALUResult <= acc_nxt[31:0];
            Zero      <= (acc_nxt[31:0] == '0);
            BadOp     <= 1'b0;
         end else if (OutReady) begin
            OutValid <= 1'b0;
         end
      end
   end

`ifdef ALU_EXEC_OVERFLOW_EN
   logic alu_ovf;

   // Signed overflow of ADD/SUB only
   always_comb begin
      alu_ovf = 1'b0;
      if (op == op_add) begin
         alu_ovf = (BusA[31] == BusB[31]) && (sum[31] != BusA[31]);
      end else if (op == op_sub) begin
         alu_ovf = (BusA[31] != BusB[31]) && (diff[31] != BusA[31]);
      end
   end

   // Overflow flag follows output-register loads
   always_ff @(posedge CLK) begin
      if (!Reset_L) begin
         Overflow <= 1'b0;
      end else if (Flush) begin
         Overflow <= Overflow;
      end else if (accept_alu) begin
         Overflow <= alu_ovf;
      end else if (wb_commit) begin
         Overflow <= 1'b0;
      end
   end
`else
   assign Overflow = 1'b0;
`endif

endmodule

// File: tb/tb_alu_exec_stage.sv
// Scoreboard bench for alu_exec_stage: stimulus pushes expected results,
// a monitor pops and compares on every output handshake.
module tb_alu_exec_stage;

   localparam logic [3:0] C_AND  = 4'h0;
   localparam logic [3:0] C_OR   = 4'h1;
   localparam logic [3:0] C_ADD  = 4'h2;
   localparam logic [3:0] C_SLL  = 4'h3;
   localparam logic [3:0] C_SRL  = 4'h4;
   localparam logic [3:0] C_MULA = 4'h5;
   localparam logic [3:0] C_SUB  = 4'h6;
   localparam logic [3:0] C_SLT  = 4'h7;
   localparam logic [3:0] C_ADDU = 4'h8;
   localparam logic [3:0] C_SUBU = 4'h9;
   localparam logic [3:0] C_XOR  = 4'hA;
   localparam logic [3:0] C_SLTU = 4'hB;
   localparam logic [3:0] C_NOR  = 4'hC;
   localparam logic [3:0] C_SRA  = 4'hD;
   localparam logic [3:0] C_LUI  = 4'hE;
   localparam logic [3:0] C_BAD  = 4'hF;

`ifdef ALU_EXEC_OVERFLOW_EN
   localparam logic OVF_EN = 1'b1;
`else
   localparam logic OVF_EN = 1'b0;
`endif

   typedef struct {
      int          id;
      logic [31:0] res;
      logic        zero;
      logic        bad;
      logic        ovf;
      logic        hl;
      logic [63:0] hilo;
   } exp_t;

   logic        CLK = 1'b0;
   logic        Reset_L;
   logic        Flush;
   logic        InValid;
   logic        InReady;
   logic [3:0]  ALUCtrl;
   logic [31:0] BusA;
   logic [31:0] BusB;
   logic [4:0]  Shamt;
   logic        OutValid;
   logic        OutReady;
   logic [31:0] ALUResult;
   logic        Zero;
   logic        Overflow;
   logic        BadOp;
   logic [31:0] HI;
   logic [31:0] LO;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;
   int   next_id  = 0;

   alu_exec_stage dut (
      .CLK       (CLK),
      .Reset_L   (Reset_L),
      .Flush     (Flush),
      .InValid   (InValid),
      .InReady   (InReady),
      .ALUCtrl   (ALUCtrl),
      .BusA      (BusA),
      .BusB      (BusB),
      .Shamt     (Shamt),
      .OutValid  (OutValid),
      .OutReady  (OutReady),
      .ALUResult (ALUResult),
      .Zero      (Zero),
      .Overflow  (Overflow),
      .BadOp     (BadOp),
      .HI        (HI),
      .LO        (LO)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, req);
      end
   endtask

   // Monitor: compare each output transfer against the scoreboard head
   always @(negedge CLK) begin
      if (Reset_L && OutValid && OutReady) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_output actual=%h required=none", ALUResult);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk($sformatf("vec%0d_result", e.id), 64'(ALUResult), 64'(e.res));
            chk($sformatf("vec%0d_zero", e.id), 64'(Zero), 64'(e.zero));
            chk($sformatf("vec%0d_badop", e.id), 64'(BadOp), 64'(e.bad));
            chk($sformatf("vec%0d_overflow", e.id), 64'(Overflow), 64'(e.ovf));
            if (e.hl) begin
               chk($sformatf("vec%0d_hilo", e.id), {HI, LO}, e.hilo);
            end
         end
      end
   end

   task automatic do_reset();
      Reset_L = 1'b0;
      InValid = 1'b0;
      Flush   = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      sb.delete();
      Reset_L = 1'b1;
   endtask

   // Offer a bundle until accepted (bounded); push expectation on acceptance
   task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, input logic push, input exp_t e);
      bit ok;
      int n;
      ok      = 0;
      n       = 0;
      InValid = 1'b1;
      ALUCtrl = op;
      BusA    = a;
      BusB    = b;
      Shamt   = sh;
      while (!ok && n < 200) begin
         @(negedge CLK);
         if (InReady) begin
            ok = 1;
            if (push) sb.push_back(e);
         end
         @(posedge CLK);
         #1;
         n++;
      end
      InValid = 1'b0;
      if (!ok) begin
         checks++;
         failures++;
         $display("FAIL send_timeout actual=notready required=accepted");
      end
   endtask

   function automatic exp_t mk(input logic [31:0] res, input logic bad, input logic ovf,
                               input logic hl, input logic [63:0] hilo);
      exp_t e;
      e.id   = next_id;
      e.res  = res;
      e.zero = (res == 32'h0);
      e.bad  = bad;
      e.ovf  = ovf & OVF_EN;
      e.hl   = hl;
      e.hilo = hilo;
      next_id++;
      return e;
   endfunction

   task automatic v(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                    input logic [4:0] sh, input logic [31:0] res, input logic bad, input logic ovf);
      send(op, a, b, sh, 1'b1, mk(res, bad, ovf, 1'b0, 64'h0));
   endtask

   task automatic mula(input logic [31:0] a, input logic [31:0] b, input logic [63:0] hilo);
      send(C_MULA, a, b, 5'd0, 1'b1, mk(hilo[31:0], 1'b0, 1'b0, 1'b1, hilo));
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(posedge CLK);
         #1;
         n++;
      end
      chk("drain_pending", 64'(sb.size()), 64'd0);
   endtask

   initial begin
      int n;
      exp_t dummy;
      InValid  = 1'b0;
      Flush    = 1'b0;
      OutReady = 1'b1;
      ALUCtrl  = 4'h0;
      BusA     = '0;
      BusB     = '0;
      Shamt    = '0;
      Reset_L  = 1'b0;
      @(posedge CLK);
      do_reset();

      chk("reset_outvalid", 64'(OutValid), 64'd0);
      chk("reset_result", 64'(ALUResult), 64'd0);
      chk("reset_zero", 64'(Zero), 64'd0);
      chk("reset_badop", 64'(BadOp), 64'd0);
      chk("reset_overflow", 64'(Overflow), 64'd0);
      chk("reset_hilo", {HI, LO}, 64'd0);
      @(negedge CLK);
      chk("reset_inready", 64'(InReady), 64'd1);
      @(posedge CLK);
      #1;

      // Single-cycle ops, back to back
      v(C_ADD,  32'h0000_0005, 32'h0000_0003, 5'd0,  32'h0000_0008, 1'b0, 1'b0);
      v(C_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 5'd0,  32'h0000_0001, 1'b0, 1'b0);
      v(C_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0,  32'h0000_0000, 1'b0, 1'b0);
      v(C_SRA,  32'h0000_0000, 32'h8000_0000, 5'd4,  32'hF800_0000, 1'b0, 1'b0);
      v(C_AND,  32'hF0F0_1234, 32'h0FF0_FFFF, 5'd0,  32'h00F0_1234, 1'b0, 1'b0);
      v(C_OR,   32'h0F00_0000, 32'h0000_00F0, 5'd0,  32'h0F00_00F0, 1'b0, 1'b0);
      v(C_XOR,  32'hFFFF_0000, 32'h0F0F_0F0F, 5'd0,  32'hF0F0_0F0F, 1'b0, 1'b0);
      v(C_NOR,  32'h0000_FFFF, 32'hFFFF_0000, 5'd0,  32'h0000_0000, 1'b0, 1'b0);
      v(C_SLL,  32'h0000_0000, 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0, 1'b0);
      v(C_SRL,  32'h0000_0000, 32'h8000_0000, 5'd4,  32'h0800_0000, 1'b0, 1'b0);
      v(C_LUI,  32'h0000_0000, 32'h1234_ABCD, 5'd0,  32'hABCD_0000, 1'b0, 1'b0);
      v(C_ADDU, 32'hFFFF_FFFF, 32'h0000_0002, 5'd0,  32'h0000_0001, 1'b0, 1'b0);
      v(C_SUBU, 32'h0000_0000, 32'h0000_0001, 5'd0,  32'hFFFF_FFFF, 1'b0, 1'b0);
      v(C_SUB,  32'h0000_0005, 32'h0000_0005, 5'd0,  32'h0000_0000, 1'b0, 1'b0);
      v(C_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 5'd0,  32'h8000_0000, 1'b0, 1'b1);
      v(C_SUB,  32'h8000_0000, 32'h0000_0001, 5'd0,  32'h7FFF_FFFF, 1'b0, 1'b1);
      v(C_ADDU, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0,  32'h8000_0000, 1'b0, 1'b0);
      v(C_SUB,  32'h0000_0001, 32'h0000_0002, 5'd0,  32'hFFFF_FFFF, 1'b0, 1'b0);
      v(C_BAD,  32'h0000_0012, 32'h0000_0034, 5'd0,  32'h0000_0000, 1'b1, 1'b0);
      drain();

      // MULA -3 * 7 from HI=LO=0, with latency measurement
      mula(32'hFFFF_FFFD, 32'h0000_0007, 64'hFFFF_FFFF_FFFF_FFEB);
      n = 0;
      while (n < 100) begin
         @(negedge CLK);
         if (InReady) break;
         n++;
      end
      chk("mula_inready_low_cycles", 64'(n), 64'd17);
      @(posedge CLK);
      #1;
      drain();

      // Two accumulating MULAs of 2^16 * 2^16
      do_reset();
      mula(32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000);
      mula(32'h0001_0000, 32'h0001_0000, 64'h0000_0002_0000_0000);
      drain();

      // Output hold with a pending bundle
      OutReady = 1'b0;
      v(C_ADD, 32'h0000_0001, 32'h0000_0001, 5'd0, 32'h0000_0002, 1'b0, 1'b0);
      InValid = 1'b1;
      ALUCtrl = C_OR;
      BusA    = 32'h0000_00F0;
      BusB    = 32'h0000_0F00;
      Shamt   = 5'd0;
      repeat (3) begin
         @(negedge CLK);
         chk("hold_inready", 64'(InReady), 64'd0);
         chk("hold_result", 64'(ALUResult), 64'h2);
         chk("hold_outvalid", 64'(OutValid), 64'd1);
      end
      @(posedge CLK);
      #1;
      OutReady = 1'b1;
      @(negedge CLK);
      chk("release_inready", 64'(InReady), 64'd1);
      sb.push_back(mk(32'h0000_0FF0, 1'b0, 1'b0, 1'b0, 64'h0));
      @(posedge CLK);
      #1;
      InValid = 1'b0;
      drain();

      // Flush on the 5th MULA cycle with HI=1, LO=2
      do_reset();
      mula(32'h0000_0001, 32'h0000_0002, 64'h0000_0000_0000_0002);
      mula(32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0002);
      drain();
      dummy = mk(32'h0, 1'b0, 1'b0, 1'b0, 64'h0);
      send(C_MULA, 32'h0000_0005, 32'h0000_0005, 5'd0, 1'b0, dummy);
      repeat (4) @(posedge CLK);
      #1;
      Flush = 1'b1;
      @(posedge CLK);
      #1;
      Flush = 1'b0;
      chk("flush_outvalid", 64'(OutValid), 64'd0);
      chk("flush_hilo", {HI, LO}, 64'h0000_0001_0000_0002);
      @(negedge CLK);
      chk("flush_inready", 64'(InReady), 64'd1);
      repeat (25) @(posedge CLK);
      #1;
      chk("flush_hilo_after", {HI, LO}, 64'h0000_0001_0000_0002);

      // Bundle offered together with Flush is refused
      InValid = 1'b1;
      ALUCtrl = C_ADD;
      BusA    = 32'h0000_0009;
      BusB    = 32'h0000_0001;
      Flush   = 1'b1;
      @(negedge CLK);
      chk("flush_offer_inready", 64'(InReady), 64'd0);
      @(posedge CLK);
      #1;
      InValid = 1'b0;
      Flush   = 1'b0;
      chk("flush_offer_outvalid", 64'(OutValid), 64'd0);
      repeat (3) @(posedge CLK);
      #1;
      chk("final_pending", 64'(sb.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global time limit
   initial begin
      #200000;
      $display("FAIL timeout actual=running required=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "time limit");
   end

endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
- Execute-stage datapath that consumes the 4-bit ALUCtrl code produced by ALU control, the operands and shamt, and registers the result into the EX/MEM boundary.
- Single-cycle ops complete in 1 cycle.
- MULA is an iterative signed 32x32 multiply that accumulates into internal HI/LO. It stalls upstream via a valid/ready handshake.
- Also supports pipeline flush.

Parameters:
- MUL_BITS_PER_CYCLE, default 2: multiplier bits retired per iteration cycle. Must divide 32. MULA iteration count N = 32/MUL_BITS_PER_CYCLE.

Ports:
- CLK  in  1  clock; all state updates on rising edge
- Reset_L  in  1  synchronous active-low reset, sampled on rising edge of CLK
- Flush  in  1  synchronous kill of in-flight and output-register contents
- InValid  in  1  operand bundle valid
- InReady  out  1  stage can accept bundle this cycle
- ALUCtrl  in  4  operation code: AND=0, OR=1, ADD=2, SLL=3, SRL=4, MULA=5, SUB=6, SLT=7, ADDU=8, SUBU=9, XOR=A, SLTU=B, NOR=C, SRA=D, LUI=E
- BusA  in  32  operand A
- BusB  in  32  operand B
- Shamt  in  5  shift amount
- OutValid  out  1  result register valid
- OutReady  in  1  downstream accepts result
- ALUResult  out  32  registered result
- Zero  out  1  registered, ALUResult==0
- Overflow  out  1  registered signed overflow (see Optional Feature)
- BadOp  out  1  registered, ALUCtrl was 4'hF or unknown
- HI  out  32  accumulator high word
- LO  out  32  accumulator low word

Behaviour:
- Reset (Reset_L=0 at edge), wins over everything:
  - State goes to IDLE.
  - OutValid, ALUResult, Zero, Overflow, BadOp, HI and LO all go to 0.
  - An in-progress MULA is abandoned.
- Accept rule: a bundle is accepted when InValid && InReady.
- InReady = (state==IDLE) && (!OutValid || OutReady).
- Single-cycle ops: an accepted bundle loads the output register on the same edge. OutValid=1 next cycle, so latency is 1.
  - ADD/SUB/ADDU/SUBU: 32-bit wrap.
  - SLT: signed compare, result 1 or 0. SLTU: unsigned compare, result 1 or 0.
  - SLL/SRL/SRA: shift BusB by Shamt. SRA is arithmetic.
  - LUI: {BusB[15:0],16'h0}.
  - NOR: ~(A|B).
  - Code F: ALUResult=0, BadOp=1.
- Output register holds while OutValid && !OutReady.
- OutValid clears on OutReady when no new bundle is accepted.
- FSM states are IDLE, MUL and WB.
  - IDLE->MUL on accepting MULA: latch |A|, |B| and product sign; clear the partial product; count=0.
  - MUL: add MUL_BITS_PER_CYCLE shifted partials per cycle; count++. Go to WB when count==N-1.
  - WB: apply sign fixup, then {HI,LO} += product (64-bit wrap). Load the output register with ALUResult=new LO and OutValid=1. Go to IDLE.
  - Total MULA latency is N+1 cycles from accept to OutValid. For default N=16 that is 17 cycles.
  - InReady=0 throughout MUL and WB.
- WB waits for output-register availability (!OutValid || OutReady) before committing. HI/LO are updated exactly once per MULA.
- Flush=1 at edge:
  - OutValid goes to 0 and state goes to IDLE.
  - A MULA in progress is aborted with HI/LO unchanged.
  - A bundle offered with Flush in the same cycle is not accepted, and InReady is forced to 0 that cycle.
- Reset mid-MULA: same as Flush, but HI/LO are also cleared.
- Zero is computed from the registered result value in every case, including MULA (LO) and BadOp (Zero=1).

Optional Feature:
- Macro: ALU_EXEC_OVERFLOW_EN.
- When defined:
  - Overflow = signed overflow of ADD (A,B same sign, result sign differs) or SUB (A,B differ in sign, result sign differs from A).
  - Overflow=0 for all other ops, including ADDU/SUBU/MULA.
  - ALUResult still carries the wrapped sum.
- When undefined: the Overflow port exists and is constant 0, and no detection logic is built.

Test Plan:
- Reset then ADD, A=32'h0000_0005, B=32'h0000_0003, OutReady=1 -> next cycle OutValid=1, ALUResult=8, Zero=0.
- SLT A=32'hFFFF_FFFF, B=1 -> ALUResult=1. SLTU with the same operands -> 0. SRA B=32'h8000_0000, Shamt=4 -> 32'hF800_0000.
- MULA A=-3, B=7 from HI=LO=0 (default parameter) -> InReady=0 for 17 cycles. Then OutValid=1, {HI,LO}=64'hFFFF_FFFF_FFFF_FFEB, ALUResult=32'hFFFF_FFEB.
- MULA A=32'h0001_0000, B=32'h0001_0000 twice -> HI=2, LO=0 after the second.
- Hold OutReady=0 with OutValid=1 and InValid=1 -> InReady=0 and ALUResult stable. Raise OutReady -> bundle accepted that edge.
- Flush at the 5th MULA cycle, HI/LO previously 0x1/0x2 -> HI=1, LO=2, OutValid=0, InReady=1 next cycle.
- With ALU_EXEC_OVERFLOW_EN: ADD 32'h7FFF_FFFF+1 -> ALUResult=32'h8000_0000, Overflow=1. Without the macro -> Overflow=0.
